// File: rtl/amadeus_markov_pkg.sv
// Shared definitions for the Markov-table merge scheduler: FSM state
// encoding, default table-ID geometry, scratch-table IDs and the operand /
// destination select triple handed to the merge engine.
package amadeus_markov_pkg;

  // Default geometry: input tables 0..7, scratch tables 8 and 9.
  localparam int MAX_TABLES_DEF = 8;
  localparam int TBL_W_DEF      = $clog2(MAX_TABLES_DEF + 2);
  localparam int CNT_W_DEF      = $clog2(MAX_TABLES_DEF + 1);

  // Scratch tables used to ping-pong intermediate merge results.
  localparam logic [TBL_W_DEF-1:0] S0 = TBL_W_DEF'(MAX_TABLES_DEF);
  localparam logic [TBL_W_DEF-1:0] S1 = TBL_W_DEF'(MAX_TABLES_DEF + 1);

  // Scheduler states, 3-bit binary encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  // Operand and destination table IDs for one pairwise merge.
  typedef struct packed {
    logic [TBL_W_DEF-1:0] src_a;
    logic [TBL_W_DEF-1:0] src_b;
    logic [TBL_W_DEF-1:0] dst;
  } merge_sel_t;

  // Table width needed to address every input table plus both scratch tables.
  function automatic int tbl_width(input int max_tables);
    return $clog2(max_tables + 2);
  endfunction

  // Width needed to hold a table count of 0..max_tables.
  function automatic int cnt_width(input int max_tables);
    return $clog2(max_tables + 1);
  endfunction

endpackage

// File: rtl/merge_watchdog.sv
// Per-merge watchdog: counts cycles while enabled and flags expiry on the
// LIMIT-th enabled cycle. Only instantiated when MERGE_TIMEOUT_EN is defined.
module merge_watchdog #(
  parameter int LIMIT = 1024,
  parameter int WD_W  = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [WD_W-1:0] LAST = WD_W'(LIMIT - 1);

  logic [WD_W-1:0] r_count;

  // Count enabled cycles; saturate at the expiry value so a stalled
  // scheduler never wraps the counter back to zero.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + WD_W'(1);
    end
  end

  // Expiry is reported combinationally so the scheduler can react in the
  // same cycle that the limit is reached.
  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/markov_merge_scheduler.sv
// Sequencer that folds up to MAX_TABLES Markov transition tables into one by
// issuing a chain of pairwise merges to a shared start/done merge engine.
// Intermediate results alternate between scratch tables MAX_TABLES and
// MAX_TABLES+1; the table holding the final result is reported with done.
// Optional build macro: MERGE_TIMEOUT_EN adds a per-merge watchdog that
// aborts the run with error=1 after TIMEOUT_CYCLES cycles without merge_done.
module markov_merge_scheduler
  import amadeus_markov_pkg::*;
#(
  parameter int MAX_TABLES     = 8,
  parameter int TBL_W          = $clog2(MAX_TABLES + 2),
  parameter int CNT_W          = $clog2(MAX_TABLES + 1),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tables,
  output logic             merge_start,
  input  logic             merge_done,
  output logic [TBL_W-1:0] src_a_sel,
  output logic [TBL_W-1:0] src_b_sel,
  output logic [TBL_W-1:0] dst_sel,
  output logic             busy,
  output logic             done,
  output logic [TBL_W-1:0] result_sel,
  output logic             error
);

  // Scratch table IDs and the largest legal table count at this geometry.
  localparam logic [TBL_W-1:0] W_S0  = TBL_W'(MAX_TABLES);
  localparam logic [TBL_W-1:0] W_S1  = TBL_W'(MAX_TABLES + 1);
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_TABLES);

  state_t           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_index;
  logic             r_pp;
  logic             r_merge_start;
  logic [TBL_W-1:0] r_src_a;
  logic [TBL_W-1:0] r_src_b;
  logic [TBL_W-1:0] r_dst;
  logic             r_busy;
  logic             r_done;
  logic [TBL_W-1:0] r_result;
  logic             r_error;

  logic [CNT_W-1:0] w_index_inc;
  logic             w_bad_count;

  // Next input table to fold in, and the legality test on a requested count.
  assign w_index_inc = r_index + CNT_W'(1);
  assign w_bad_count = (num_tables == '0) || (num_tables > MAX_N);

`ifdef MERGE_TIMEOUT_EN
  logic w_expired;

  // The watchdog restarts while the merge is being issued and runs only
  // while the scheduler waits for the engine.
  merge_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_merge_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (r_state == ST_ISSUE),
    .i_enable  (r_state == ST_WAIT),
    .o_expired (w_expired)
  );
`endif

  // Scheduler FSM; every output is registered and updated on the transition
  // into the state that owns it, so pulses line up with the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_num         <= '0;
      r_index       <= '0;
      r_pp          <= 1'b0;
      r_merge_start <= 1'b0;
      r_src_a       <= '0;
      r_src_b       <= '0;
      r_dst         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_error       <= 1'b0;
    end else begin
      r_merge_start <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num   <= num_tables;
            r_index <= CNT_W'(1);
            r_pp    <= 1'b0;
            r_error <= 1'b0;
            if (w_bad_count) begin
              // Nothing sensible to merge: report table 0 with error.
              r_error  <= 1'b1;
              r_result <= '0;
              r_done   <= 1'b1;
              r_state  <= ST_FINISH;
            end else if (num_tables == CNT_W'(1)) begin
              // A single table is already the result.
              r_result <= '0;
              r_done   <= 1'b1;
              r_state  <= ST_FINISH;
            end else begin
              // First merge: table 0 with table 1 into scratch S0.
              r_busy        <= 1'b1;
              r_merge_start <= 1'b1;
              r_src_a       <= '0;
              r_src_b       <= TBL_W'(1);
              r_dst         <= W_S0;
              r_state       <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (merge_done) begin
            r_state <= ST_ADVANCE;
`ifdef MERGE_TIMEOUT_EN
          end else if (w_expired) begin
            // The operand A of the stalled merge is the last completed
            // result (table 0 when the very first merge stalled).
            r_error  <= 1'b1;
            r_result <= r_src_a;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_FINISH;
`endif
          end
        end

        ST_ADVANCE: begin
          r_index <= w_index_inc;
          r_pp    <= ~r_pp;
          if (w_index_inc == r_num) begin
            r_result <= r_dst;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_FINISH;
          end else begin
            // Fold the next input table into the previous result, writing
            // to the scratch table that is not currently being read.
            r_merge_start <= 1'b1;
            r_src_a       <= r_dst;
            r_src_b       <= TBL_W'(w_index_inc);
            r_dst         <= r_pp ? W_S0 : W_S1;
            r_state       <= ST_ISSUE;
          end
        end

        ST_FINISH: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign merge_start = r_merge_start;
  assign src_a_sel   = r_src_a;
  assign src_b_sel   = r_src_b;
  assign dst_sel     = r_dst;
  assign busy        = r_busy;
  assign done        = r_done;
  assign result_sel  = r_result;
  assign error       = r_error;

endmodule

// File: doc/markov_merge_scheduler.md
Name: markov_merge_scheduler

Overview:
Sequencer that folds up to MAX_TABLES first-order Markov transition tables into one by issuing a chain of pairwise merges to a single shared merge engine. The engine uses a start/done handshake. The scheduler sits between the song-analysis front end, which supplies the table count, and the merge datapath. Intermediate results ping-pong between two scratch tables; the final table ID is reported with done.

Parameters:
MAX_TABLES, 8, maximum number of input tables; input table IDs are 0..MAX_TABLES-1
TBL_W, $clog2(MAX_TABLES+2), width of table ID fields; scratch IDs are S0=MAX_TABLES and S1=MAX_TABLES+1
CNT_W, $clog2(MAX_TABLES+1), width of num_tables
TIMEOUT_CYCLES, 1024, watchdog limit per merge; used only with MERGE_TIMEOUT_EN

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  request a merge run; sampled only in IDLE
num_tables  in  CNT_W  number of input tables; latched on accepted start
merge_start  out  1  one-cycle pulse to the merge engine
merge_done  in  1  one-cycle pulse from the engine; the current merge is complete
src_a_sel  out  TBL_W  first operand table ID
src_b_sel  out  TBL_W  second operand table ID
dst_sel  out  TBL_W  destination table ID
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
result_sel  out  TBL_W  table holding the merged result; valid while done is high and held until the next accepted start
error  out  1  sticky status flag; cleared on the next accepted start or on reset

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; internal index=0; ping-pong bit=0. Asserting reset mid-run aborts the run at that edge; no done is issued.
- States: IDLE, ISSUE, WAIT, ADVANCE, FINISH. Encoding is binary, 3 bits.
- IDLE:
  - start=1 latches num_tables (N), clears error, and sets index=1.
  - N>=2 -> ISSUE.
  - N==1 -> FINISH with result_sel=0.
  - N==0 or N>MAX_TABLES -> FINISH with error=1 and result_sel=0.
- ISSUE: merge_start=1 for exactly this cycle -> WAIT.
  - src_b_sel=index.
  - src_a_sel = 0 for the first merge; otherwise the previous dst.
  - dst_sel = S0 if ping-pong bit is 0, else S1.
  - All three selects are registered and held stable from ISSUE until the following ADVANCE.
- WAIT: merge_done=1 -> ADVANCE. merge_done is ignored in every other state.
- ADVANCE: index+=1 and the ping-pong bit toggles. If the new index==N -> FINISH with result_sel=last dst; otherwise -> ISSUE.
- FINISH: done=1 for this cycle only, busy=0 -> IDLE. A new start is accepted on the next cycle at the earliest.
- start while busy is ignored; num_tables changes after latching have no effect.
- Latency: start accepted at cycle 0 and engine latency L (merge_start to merge_done, L>=1) gives merge_start at cycles 1+k(L+2) and done at cycle (N-1)(L+2)+1.
- Index arithmetic is unsigned CNT_W; no wrap occurs because N<=MAX_TABLES is checked at start.

Optional Feature:
MERGE_TIMEOUT_EN
- Defined: a cycle counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without merge_done, the block sets error=1 and goes to FINISH. done pulses with result_sel=last completed dst, or 0 if no merge has completed. A merge_done arriving on the timeout cycle takes priority: the merge counts as complete and no error is raised.
- Undefined: no counter is instantiated; WAIT waits indefinitely.

Decomposition:
- Shared package amadeus_markov_pkg: state encodings, scratch ID constants S0/S1, TBL_W/CNT_W derivation, and a merge-handshake struct type for the select triple.
- One sub-module, merge_watchdog: counter with clear/enable/expired outputs; instantiated only under MERGE_TIMEOUT_EN.

Test Plan:
- MAX_TABLES=8, N=3, engine L=4 -> merge_start at cycles 1 and 7 with selects (0,1,8) then (8,2,9); done at cycle 13; result_sel=9; busy high on cycles 1-12.
- N=1 -> no merge_start; done at cycle 1; result_sel=0; error=0.
- N=0, then N=9 -> done at cycle 1 with error=1 each time; the next valid start with N=2 clears error.
- N=8, L=1 -> 7 merges with dst alternating 8,9,8,…; final result_sel=8; start pulses mid-run and merge_done pulses in ISSUE/ADVANCE are ignored.
- Reset asserted during the 2nd WAIT of an N=4 run -> next cycle: IDLE with all outputs 0; no done.
- MERGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never responds on the 2nd merge -> error=1 and done about 16 cycles after merge_start; result_sel=8. Also check merge_done on exactly the timeout cycle -> no error.
